// File: rtl/mem_burst_responder_pkg.sv
// Shared main-bus definitions: burst length, responder state encoding and
// the page-field helper used when decoding an address phase.
package mcDefs;

  localparam int BURST_LEN = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } resp_state_t;

  // Page number carried in the top nibble of an address-phase word.
  function automatic logic [3:0] page_of(input logic [15:0] addr);
    return addr[15:12];
  endfunction

endpackage

// File: rtl/mem_burst_ram.sv
// Single-port RAM with synchronous write and registered read. The read
// register doubles as the responder's bus output register.
module mem_burst_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Storage write and read-register load share one address each edge.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_burst_responder.sv
// Slave end of the multiplexed address/data burst bus for one memory page.
// Decodes a one-cycle address phase, then serves a 4-beat wrapping burst:
// writes land in local RAM, reads are driven onto AddrData with zero wait
// states by presenting the next beat's address to the RAM one cycle early.
module mem_burst_responder
  import mcDefs::*;
#(
  parameter logic [3:0] PAGE   = 4'h2,
  parameter int         ADDR_W = 12
) (
  input  logic        clk,
  input  logic        resetH,
  input  logic        AddrValid,
  input  logic        rw,
  inout  wire  [15:0] AddrData,
  output logic        busy,
  output logic        protErr
);

  resp_state_t       r_state, w_state_nxt;
  logic [1:0]        r_beat, w_beat_nxt;
  logic [ADDR_W-1:0] r_base, w_base_nxt;
  logic              r_prot_err, w_prot_nxt;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [15:0]       w_ram_rdata;
  logic              w_last;

  // Word address of a beat: low two bits wrap inside the aligned 4-word line.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [1:0] k);
    logic [1:0] lo;
    lo = b[1:0] + k;
    return {b[ADDR_W-1:2], lo};
  endfunction

  assign w_last = (r_beat == 2'(BURST_LEN - 1));

  // Next-state, beat counter, RAM address/strobe and error flag.
  // In IDLE the RAM is addressed straight from the bus so that beat-0 read
  // data is already in the output register one edge after the address phase.
  // In RD the RAM looks one beat ahead for the same reason.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_base_nxt  = r_base;
    w_prot_nxt  = r_prot_err;
    w_ram_we    = 1'b0;
    w_ram_addr  = AddrData[ADDR_W-1:0];
    unique case (r_state)
      IDLE: begin
        if (AddrValid && (page_of(AddrData) == PAGE)) begin
          w_base_nxt  = AddrData[ADDR_W-1:0];
          w_beat_nxt  = 2'd0;
          w_state_nxt = rw ? RD : WR;
        end
      end
      RD: begin
        w_ram_addr = beat_addr(r_base, r_beat + 2'd1);
        w_beat_nxt = r_beat + 2'd1;
        if (w_last)    w_state_nxt = IDLE;
        if (AddrValid) w_prot_nxt  = 1'b1;
      end
      WR: begin
        w_ram_addr = beat_addr(r_base, r_beat);
        w_ram_we   = 1'b1;
        w_beat_nxt = r_beat + 2'd1;
        if (w_last)    w_state_nxt = IDLE;
        if (AddrValid) w_prot_nxt  = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control state with asynchronous reset; reset releases the bus at once.
  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      r_state    <= IDLE;
      r_beat     <= 2'd0;
      r_prot_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat     <= w_beat_nxt;
      r_prot_err <= w_prot_nxt;
    end
  end

  // Burst base offset; only meaningful once a burst has been accepted.
  always_ff @(posedge clk) begin
    r_base <= w_base_nxt;
  end

  mem_burst_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (16)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (AddrData),
    .o_rdata (w_ram_rdata)
  );

  assign AddrData = (r_state == RD) ? w_ram_rdata : 16'bz;
  assign busy     = (r_state != IDLE);
  assign protErr  = r_prot_err;

endmodule

// File: tb/tb_mem_burst_responder.sv
// Bench for mem_burst_responder: directed bursts with literal expectations,
// then randomized bursts, all checked every cycle against a word-array model
// of the memory page and the burst rules.
module tb_mem_burst_responder;

  logic        clk = 1'b0;
  logic        resetH = 1'b0;
  logic        AddrValid = 1'b0;
  logic        rw = 1'b0;
  wire  [15:0] AddrData;
  logic        busy, protErr;
  logic [15:0] m_drv = 16'h0;
  logic        m_oe = 1'b0;

  assign AddrData = m_oe ? m_drv : 16'bz;

  // Released bus floats high so any stray drive shows up as a value change.
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup pu (AddrData[g]);
  end

  always #5 clk = ~clk;

  mem_burst_responder #(.PAGE(4'h2), .ADDR_W(12)) dut (
    .clk       (clk),
    .resetH    (resetH),
    .AddrValid (AddrValid),
    .rw        (rw),
    .AddrData  (AddrData),
    .busy      (busy),
    .protErr   (protErr)
  );

  int checks = 0;
  int errors = 0;

  // Model of the page and the expectations for the current cycle.
  logic [15:0] mmem   [4096];
  bit          mvalid [4096];
  bit          model_prot = 1'b0;
  bit          chk_on = 1'b0;
  bit          exp_busy = 1'b0;
  bit          exp_prot = 1'b0;
  bit          exp_chk_bus = 1'b1;
  logic [15:0] exp_bus = 16'hFFFF;

  logic [15:0] obs [4];
  int          busycnt;

  // Per-cycle comparison of every observable output.
  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy t=%0t got %b want %b", $time, busy, exp_busy);
      end
      checks++;
      if (protErr !== exp_prot) begin
        errors++;
        $display("FAIL protErr t=%0t got %b want %b", $time, protErr, exp_prot);
      end
      if (exp_chk_bus) begin
        checks++;
        if (AddrData !== exp_bus) begin
          errors++;
          $display("FAIL bus t=%0t got %h want %h", $time, AddrData, exp_bus);
        end
      end
    end
  end

  task automatic chk_lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    AddrValid   = 1'b0;
    m_oe        = 1'b0;
    rw          = 1'($urandom);
    exp_busy    = 1'b0;
    exp_prot    = model_prot;
    exp_chk_bus = 1'b1;
    exp_bus     = 16'hFFFF;
    @(negedge clk);
  endtask

  // One address phase plus four beat cycles. err_beat/rst_beat select a beat
  // in which to raise AddrValid or assert reset (-1 for none).
  task automatic burst(input bit rd, input logic [15:0] addr,
                       input logic [15:0] wd [4], input int err_beat,
                       input int rst_beat);
    bit hit;
    int base;
    bit stop;
    hit  = (addr[15:12] == 4'h2);
    base = int'(addr[11:0]);
    busycnt = 0;
    stop = 1'b0;
    @(posedge clk); #1;
    AddrValid   = 1'b1;
    rw          = rd;
    m_drv       = addr;
    m_oe        = 1'b1;
    exp_busy    = 1'b0;
    exp_prot    = model_prot;
    exp_chk_bus = 1'b1;
    exp_bus     = addr;
    @(negedge clk);
    for (int i = 0; i < 4 && !stop; i++) begin
      int a;
      a = (base & 'hFFC) | ((base + i) & 3);
      @(posedge clk); #1;
      AddrValid = (i == err_beat);
      rw        = 1'($urandom);
      if (rd) m_oe = 1'b0;
      else begin
        m_oe  = 1'b1;
        m_drv = wd[i];
      end
      exp_busy = hit;
      exp_prot = model_prot;
      if (hit && rd) begin
        exp_chk_bus = mvalid[a];
        exp_bus     = mmem[a];
      end else if (!rd) begin
        exp_chk_bus = 1'b1;
        exp_bus     = wd[i];
      end else begin
        exp_chk_bus = 1'b1;
        exp_bus     = 16'hFFFF;
      end
      if (i == rst_beat) begin
        #2;
        resetH      = 1'b1;
        m_oe        = 1'b0;
        AddrValid   = 1'b0;
        exp_busy    = 1'b0;
        exp_prot    = 1'b0;
        exp_chk_bus = 1'b1;
        exp_bus     = 16'hFFFF;
        model_prot  = 1'b0;
      end
      @(negedge clk);
      obs[i] = AddrData;
      if (busy) busycnt++;
      if (i == rst_beat) begin
        @(posedge clk); #1;
        resetH = 1'b0;
        stop   = 1'b1;
      end else begin
        if (hit && !rd) begin
          mmem[a]   = wd[i];
          mvalid[a] = 1'b1;
        end
        if (hit && i == err_beat) model_prot = 1'b1;
      end
    end
  endtask

  logic [15:0] d [4];
  logic [15:0] e [4];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mmem[i]   = 16'h0;
      mvalid[i] = 1'b0;
    end
    #1 resetH = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    chk_lit("reset_busy", int'(busy), 0);
    chk_lit("reset_prot", int'(protErr), 0);
    chk_lit("reset_bus", int'(AddrData), 'hFFFF);
    @(posedge clk); #1;
    resetH = 1'b0;

    // Fill offsets 0x000..0x03F with 0x0C00 | offset.
    for (int l = 0; l < 16; l++) begin
      for (int k = 0; k < 4; k++) d[k] = 16'h0C00 | 16'(l * 4 + k);
      burst(1'b0, 16'h2000 | 16'(l * 4), d, -1, -1);
    end
    idle_cycle();

    d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    burst(1'b0, 16'h2004, d, -1, -1);
    chk_lit("wr_busy_cycles", busycnt, 4);
    idle_cycle();
    burst(1'b1, 16'h2004, d, -1, -1);
    chk_lit("rd_busy_cycles", busycnt, 4);
    for (int k = 0; k < 4; k++) chk_lit("rd2004_beat", int'(obs[k]), int'(d[k]));
    idle_cycle();

    burst(1'b1, 16'h2007, d, -1, -1);
    e = '{16'h4444, 16'h1111, 16'h2222, 16'h3333};
    for (int k = 0; k < 4; k++) chk_lit("rd2007_wrap", int'(obs[k]), int'(e[k]));
    idle_cycle();

    e = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    burst(1'b0, 16'h3004, e, -1, -1);
    chk_lit("mismatch_busy", busycnt, 0);
    idle_cycle();
    burst(1'b1, 16'h2004, d, -1, -1);
    chk_lit("after_mismatch", int'(obs[0]), 'h1111);
    idle_cycle();

    burst(1'b1, 16'h2004, d, 1, -1);
    for (int k = 0; k < 4; k++) chk_lit("err_burst_beat", int'(obs[k]), int'(d[k]));
    idle_cycle();
    chk_lit("prot_sticky", int'(protErr), 1);

    e = '{16'h5555, 16'h6666, 16'h7777, 16'h8888};
    burst(1'b0, 16'h2010, e, -1, 2);
    chk_lit("rst_busy", int'(busy), 0);
    chk_lit("rst_prot", int'(protErr), 0);
    idle_cycle();
    burst(1'b1, 16'h2010, e, -1, -1);
    chk_lit("rst_rd0", int'(obs[0]), 'h5555);
    chk_lit("rst_rd1", int'(obs[1]), 'h6666);
    chk_lit("rst_rd2", int'(obs[2]), 'h0C12);
    chk_lit("rst_rd3", int'(obs[3]), 'h0C13);
    idle_cycle();

    d = '{16'h9A01, 16'h9A02, 16'h9A03, 16'h9A04};
    burst(1'b0, 16'h2020, d, -1, -1);
    burst(1'b1, 16'h2020, d, -1, -1);
    chk_lit("b2b_busy", busycnt, 4);
    for (int k = 0; k < 4; k++) chk_lit("b2b_rd", int'(obs[k]), int'(d[k]));

    // Randomized traffic over the filled region.
    for (int n = 0; n < 200; n++) begin
      bit          rd;
      logic [15:0] addr;
      int          eb, rb, gap;
      rd   = 1'($urandom);
      addr = {($urandom_range(0, 9) == 0) ? 4'h3 : 4'h2,
              12'($urandom_range(0, 63))};
      for (int k = 0; k < 4; k++) d[k] = 16'($urandom_range(0, 'hFFFE));
      eb = (addr[15:12] == 4'h2 && $urandom_range(0, 7) == 0) ?
           int'($urandom_range(0, 3)) : -1;
      rb = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
      burst(rd, addr, d, eb, rb);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) idle_cycle();
    end
    idle_cycle();
    idle_cycle();
    chk_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
